// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode encodings.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int CTRL_W        = 4;
   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM       = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'd0;
   localparam logic [1:0] MODE_PERIODIC = 2'd1;

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer on the processor bus: CTRL/PRESET/COUNT
// registers, a four-state load/count/interrupt FSM and a masked IRQ line.
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] RESET_PRESET = 32'd0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Sel,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic        IRQ
);

   timer_state_e      state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [31:0]       preset_q, preset_d;
   logic [31:0]       count_q, count_d;
   logic              irq_flag_q, irq_flag_d;

   logic enable;
   logic periodic;
   logic wr_ctrl;
   logic wr_preset;
   logic load_cnt, dec_cnt, expire, fsm_clr_en, fsm_clr_irq;

   assign enable    = ctrl_q[CTRL_EN];
   assign periodic  = (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_PERIODIC);
   assign wr_ctrl   = Sel & WE & (Addr == ADDR_CTRL);
   assign wr_preset = Sel & WE & (Addr == ADDR_PRESET);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (enable) state_d = LOAD;
         LOAD: state_d = CNT;
         CNT: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (count_q <= 32'd1) begin
               state_d = INT;
            end
         end
         INT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_cnt    = 1'b0;
      dec_cnt     = 1'b0;
      expire      = 1'b0;
      fsm_clr_en  = 1'b0;
      fsm_clr_irq = 1'b0;
      case (state_q)
         LOAD: load_cnt = 1'b1;
         CNT: begin
            if (enable) begin
               if (count_q > 32'd1) begin
                  dec_cnt = 1'b1;
               end else begin
                  expire = 1'b1;
               end
            end
         end
         INT: begin
            if (periodic) begin
               fsm_clr_irq = 1'b1;
            end else begin
               fsm_clr_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // A bus CTRL write overrides the FSM's Enable clear; a fresh expiry
   // outranks a coincident flag clear so no interrupt is ever lost.
   always_comb begin
      ctrl_d = ctrl_q;
      if (fsm_clr_en) begin
         ctrl_d[CTRL_EN] = 1'b0;
      end
      if (wr_ctrl) begin
         ctrl_d = DIn[CTRL_W-1:0];
      end

      preset_d = wr_preset ? DIn : preset_q;

      count_d = count_q;
      if (load_cnt) begin
         count_d = preset_q;
      end else if (dec_cnt) begin
         count_d = count_q - 32'd1;
      end else if (expire) begin
         count_d = 32'd0;
      end

      irq_flag_d = irq_flag_q;
      if (wr_ctrl || fsm_clr_irq) begin
         irq_flag_d = 1'b0;
      end
      if (expire) begin
         irq_flag_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ctrl_q     <= '0;
         preset_q   <= RESET_PRESET;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      DOut = '0;
      case (Addr)
         ADDR_CTRL:   DOut = {{(32-CTRL_W){1'b0}}, ctrl_q};
         ADDR_PRESET: DOut = preset_q;
         ADDR_COUNT:  DOut = count_q;
         default:     DOut = '0;
      endcase
   end

   assign IRQ = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios with randomized
// presets/modes, checked against a cycle-count arithmetic model.
module tb_timer_dev;
   import timer_pkg::*;

   localparam logic [31:0] RST_P = 32'h0000_00A5;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Sel;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic        IRQ;

   int n_checks = 0;
   int n_fail   = 0;

   timer_dev #(.RESET_PRESET(RST_P)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Sel   (Sel),
      .Addr  (Addr),
      .WE    (WE),
      .DIn   (DIn),
      .DOut  (DOut),
      .IRQ   (IRQ)
   );

   always #5 Clk = ~Clk;

   // Expected COUNT k edges after the enabling CTRL write (edge 0).
   function automatic logic [31:0] m_count(input int p, input int k, input logic per);
      int pe, j;
      pe = (p == 0) ? 1 : p;
      if (k < 2) return 32'd0;
      j = k - 2;
      if (per) j = j % (pe + 3);
      return (j < p) ? 32'(p - j) : 32'd0;
   endfunction

   function automatic logic m_irq(input int p, input int k, input logic per, input logic im);
      int pe, j;
      pe = (p == 0) ? 1 : p;
      if (k < 2) return 1'b0;
      j = k - 2;
      if (per) return im && ((j % (pe + 3)) == pe);
      return im && (j >= pe);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      check(tag, DOut, exp);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      Sel  = 1'b1;
      WE   = 1'b1;
      Addr = a;
      DIn  = d;
      tick();
      Sel  = 1'b0;
      WE   = 1'b0;
      DIn  = $urandom;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic run_chk(input string tag, input int p, input int k0, input int k1,
                          input logic per, input logic im);
      for (int k = k0; k <= k1; k++) begin
         tick();
         read_chk({tag, "_count"}, ADDR_COUNT, m_count(p, k, per));
         check({tag, "_irq"}, {31'b0, IRQ}, {31'b0, m_irq(p, k, per, im)});
      end
   endtask

   initial begin
      int p;
      int m;
      logic [31:0] ctrlv;

      Reset = 1'b1;
      Sel   = 1'b0;
      WE    = 1'b0;
      Addr  = ADDR_CTRL;
      DIn   = '0;
      repeat (3) tick();
      Reset = 1'b0;

      // Reset values, and the FSM stays idle afterwards
      read_chk("rst_ctrl", ADDR_CTRL, 32'd0);
      read_chk("rst_preset", ADDR_PRESET, RST_P);
      read_chk("rst_count", ADDR_COUNT, 32'd0);
      check("rst_irq", {31'b0, IRQ}, 32'd0);
      repeat (3) tick();
      read_chk("idle_count", ADDR_COUNT, 32'd0);

      // One-shot, modes 0/2/3
      for (int r = 0; r < 3; r++) begin
         p = (r == 0) ? 5 : int'($urandom_range(1, 12));
         m = (r == 0) ? 0 : int'($urandom_range(0, 2));
         if (m != 0) m = m + 1;
         ctrlv = 32'h9 | 32'(m << 1);
         do_reset();
         bus_write(ADDR_PRESET, 32'(p));
         read_chk("os_preset_vis", ADDR_PRESET, 32'(p));
         bus_write(ADDR_CTRL, ctrlv);
         run_chk("oneshot", p, 1, p + 22, 1'b0, 1'b1);
         read_chk("os_ctrl_after", ADDR_CTRL, ctrlv & 32'hE);
         bus_write(ADDR_CTRL, 32'd0);
         check("os_irq_drop", {31'b0, IRQ}, 32'd0);
      end

      // Reset asserted mid-count at COUNT = 37
      do_reset();
      bus_write(ADDR_PRESET, 32'd40);
      bus_write(ADDR_CTRL, 32'h9);
      run_chk("pre_rst", 40, 1, 5, 1'b0, 1'b1);
      read_chk("mid_count37", ADDR_COUNT, 32'd37);
      do_reset();
      read_chk("mrst_ctrl", ADDR_CTRL, 32'd0);
      read_chk("mrst_count", ADDR_COUNT, 32'd0);
      read_chk("mrst_preset", ADDR_PRESET, RST_P);
      check("mrst_irq", {31'b0, IRQ}, 32'd0);
      repeat (4) tick();
      read_chk("mrst_idle", ADDR_COUNT, 32'd0);

      // Periodic, including PRESET = 0
      for (int r = 0; r < 3; r++) begin
         p = (r == 0) ? 4 : (r == 1) ? 0 : int'($urandom_range(1, 8));
         do_reset();
         bus_write(ADDR_PRESET, 32'(p));
         bus_write(ADDR_CTRL, 32'hB);
         run_chk("periodic", p, 1, 2 + 5 * (((p == 0) ? 1 : p) + 3), 1'b1, 1'b1);
         read_chk("per_ctrl", ADDR_CTRL, 32'hB);
      end

      // PRESET = 0 one-shot: expiry one edge after the CNT entry
      do_reset();
      bus_write(ADDR_PRESET, 32'd0);
      bus_write(ADDR_CTRL, 32'h9);
      run_chk("preset0", 0, 1, 6, 1'b0, 1'b1);

      // Masked interrupt
      p = int'($urandom_range(2, 6));
      do_reset();
      bus_write(ADDR_PRESET, 32'(p));
      bus_write(ADDR_CTRL, 32'h1);
      run_chk("mask", p, 1, p + 8, 1'b0, 1'b0);
      read_chk("mask_ctrl", ADDR_CTRL, 32'd0);

      // PRESET rewritten 3 -> 100 during CNT in periodic mode
      do_reset();
      bus_write(ADDR_PRESET, 32'd3);
      bus_write(ADDR_CTRL, 32'hB);
      run_chk("pchg_a", 3, 1, 2, 1'b1, 1'b1);
      bus_write(ADDR_PRESET, 32'd100);
      read_chk("pchg_k3", ADDR_COUNT, m_count(3, 3, 1'b1));
      run_chk("pchg_b", 3, 4, 7, 1'b1, 1'b1);
      run_chk("pchg_c", 100, 2, 103, 1'b1, 1'b1);

      // CTRL write coinciding with the one-shot Enable clear in INT
      do_reset();
      bus_write(ADDR_PRESET, 32'd2);
      bus_write(ADDR_CTRL, 32'h9);
      run_chk("race_a", 2, 1, 4, 1'b0, 1'b1);
      bus_write(ADDR_CTRL, 32'h9);
      read_chk("race_ctrl", ADDR_CTRL, 32'h9);
      check("race_irq", {31'b0, IRQ}, 32'd0);
      run_chk("race_b", 2, 1, 8, 1'b0, 1'b1);

      // Disable mid-CNT at COUNT = 9, then writes to COUNT/reserved
      do_reset();
      bus_write(ADDR_PRESET, 32'd20);
      bus_write(ADDR_CTRL, 32'h9);
      run_chk("dis_run", 20, 1, 12, 1'b0, 1'b1);
      bus_write(ADDR_CTRL, 32'h8);
      read_chk("dis_count", ADDR_COUNT, 32'd9);
      repeat (5) tick();
      read_chk("dis_hold", ADDR_COUNT, 32'd9);
      read_chk("dis_ctrl", ADDR_CTRL, 32'h8);
      check("dis_irq", {31'b0, IRQ}, 32'd0);
      bus_write(ADDR_COUNT, 32'hDEAD_BEEF);
      bus_write(2'd3, 32'hFFFF_FFFF);
      read_chk("ro_count", ADDR_COUNT, 32'd9);
      read_chk("ro_ctrl", ADDR_CTRL, 32'h8);
      read_chk("ro_preset", ADDR_PRESET, 32'd20);
      read_chk("rsv_read", 2'd3, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
